// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI-style memory endpoint.
package axi_mem_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WR_DATA = 2'b01,
        WR_RESP = 2'b10,
        RD_DATA = 2'b11
    } state_t;

    // A burst response is sticky: once any beat errors, the burst reports SLVERR.
    function automatic resp_t merge_resp(input resp_t cur, input logic err);
        if (err || (cur == SLVERR)) begin
            return SLVERR;
        end else begin
            return OKAY;
        end
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Single-port DEPTH x DATA_W word array: byte-strobed synchronous write,
// combinational read from the same address. Contents are never cleared.
module axi_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane write: only lanes with their strobe set are updated
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI-style memory endpoint: accepts AW/W/AR streams, runs one INCR burst at a
// time on a single-port array and returns B/R streams.
// Optional feature: define MEM_BOUNDS_CHECK_EN to suppress beats whose
// untruncated word index is >= DEPTH and flag the burst SLVERR; otherwise the
// index wraps modulo DEPTH.
module axi_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic [7:0]            aw_len,
    input  logic                  aw_val,
    output logic                  aw_rdy,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_last,
    input  logic                  w_val,
    output logic                  w_rdy,
    output logic [1:0]            b_resp,
    output logic                  b_val,
    input  logic                  b_rdy,
    input  logic [ADDR_W-1:0]     ar_addr,
    input  logic [7:0]            ar_len,
    input  logic                  ar_val,
    output logic                  ar_rdy,
    output logic [DATA_W-1:0]     r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  r_val,
    input  logic                  r_rdy
);

    import axi_mem_pkg::*;

    localparam int LSB    = $clog2(DATA_W/8);
    localparam int MEM_AW = $clog2(DEPTH);
    // One spare bit so the running index never wraps before the bounds check sees it
    localparam int IDX_W  = ADDR_W - LSB + 1;

    state_t              state_q,    state_d;
    logic                wr_first_q, wr_first_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [LEN_W-1:0]    cnt_q,      cnt_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic                err_q,      err_d;
    logic                b_val_q,    b_val_d;
    resp_t               b_resp_q,   b_resp_d;
    logic                r_val_q,    r_val_d;
    logic [DATA_W-1:0]   r_data_q,   r_data_d;
    logic                r_last_q,   r_last_d;
    resp_t               r_resp_q,   r_resp_d;

    logic                grant_w_s;
    logic                grant_r_s;
    logic                both_val_s;
    logic                w_rdy_s;
    logic                final_beat_s;
    logic                beat_err_s;
    logic [IDX_W-1:0]    aw_start_idx_s;
    logic [IDX_W-1:0]    ar_start_idx_s;
    logic [IDX_W-1:0]    mem_idx_s;
    logic                mem_we_s;
    logic                mem_oob_s;
    logic [DATA_W-1:0]   mem_rdata_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                addr_bits_unused;

    assign aw_start_idx_s = {1'b0, aw_addr[ADDR_W-1:LSB]};
    assign ar_start_idx_s = {1'b0, ar_addr[ADDR_W-1:LSB]};
    assign both_val_s     = aw_val && ar_val;
    assign w_rdy_s        = (state_q == WR_DATA) && !rst;
    assign final_beat_s   = (cnt_q == len_q);

    // Byte-offset bits and index bits above the array are intentionally dropped
    assign addr_bits_unused = ^{aw_addr[LSB-1:0], ar_addr[LSB-1:0], mem_idx_s[IDX_W-1:MEM_AW]};

`ifdef MEM_BOUNDS_CHECK_EN
    assign mem_oob_s = (mem_idx_s >= IDX_W'(DEPTH));
`else
    assign mem_oob_s = 1'b0;
`endif

    assign rd_word_s = mem_oob_s ? {DATA_W{1'b0}} : mem_rdata_s;

    // Arbitration in IDLE: ready goes only to the granted channel; contested grants alternate
    always_comb begin
        grant_w_s = 1'b0;
        grant_r_s = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            if (both_val_s) begin
                if (wr_first_q) begin
                    grant_w_s = 1'b1;
                end else begin
                    grant_r_s = 1'b1;
                end
            end else if (aw_val) begin
                grant_w_s = 1'b1;
            end else if (ar_val) begin
                grant_r_s = 1'b1;
            end else begin
                grant_w_s = 1'b0;
            end
        end else begin
            grant_r_s = 1'b0;
        end
    end

    // Single array port: the address follows whichever phase owns it this cycle
    always_comb begin
        mem_idx_s = idx_q;
        mem_we_s  = 1'b0;
        case (state_q)
            IDLE:    mem_idx_s = ar_start_idx_s;
            WR_DATA: begin
                mem_idx_s = idx_q;
                mem_we_s  = w_val && w_rdy_s && !mem_oob_s;
            end
            RD_DATA: mem_idx_s = idx_q + IDX_W'(1);
            WR_RESP: mem_idx_s = idx_q;
            default: mem_idx_s = idx_q;
        endcase
    end

    axi_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .addr  (mem_idx_s[MEM_AW-1:0]),
        .we    (mem_we_s),
        .wstrb (w_strb),
        .wdata (w_data),
        .rdata (mem_rdata_s)
    );

    // A write beat errs if w_last disagrees with the counted final beat or lands out of range
    always_comb begin
        beat_err_s = (w_last != final_beat_s) || mem_oob_s;
    end

    // Next-state and registered-output logic for the transaction FSM
    always_comb begin
        state_d    = state_q;
        wr_first_d = wr_first_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        b_val_d    = b_val_q;
        b_resp_d   = b_resp_q;
        r_val_d    = r_val_q;
        r_data_d   = r_data_q;
        r_last_d   = r_last_q;
        r_resp_d   = r_resp_q;
        case (state_q)
            IDLE: begin
                if (grant_w_s) begin
                    if (both_val_s) begin
                        wr_first_d = 1'b0;
                    end else begin
                        wr_first_d = wr_first_q;
                    end
                    idx_d   = aw_start_idx_s;
                    len_d   = aw_len;
                    cnt_d   = {LEN_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = WR_DATA;
                end else if (grant_r_s) begin
                    if (both_val_s) begin
                        wr_first_d = 1'b1;
                    end else begin
                        wr_first_d = wr_first_q;
                    end
                    idx_d    = ar_start_idx_s;
                    len_d    = ar_len;
                    cnt_d    = {LEN_W{1'b0}};
                    r_val_d  = 1'b1;
                    r_data_d = rd_word_s;
                    r_last_d = (ar_len == 8'd0);
                    r_resp_d = merge_resp(OKAY, mem_oob_s);
                    state_d  = RD_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (w_val) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    if (final_beat_s) begin
                        b_val_d  = 1'b1;
                        b_resp_d = merge_resp(err_q ? SLVERR : OKAY, beat_err_s);
                        err_d    = 1'b0;
                        state_d  = WR_RESP;
                    end else begin
                        err_d = err_q || beat_err_s;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (b_rdy) begin
                    b_val_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_DATA: begin
                if (r_rdy) begin
                    if (r_last_q) begin
                        r_val_d  = 1'b0;
                        r_last_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        cnt_d    = cnt_q + LEN_W'(1);
                        r_data_d = rd_word_s;
                        r_last_d = ((cnt_q + LEN_W'(1)) == len_q);
                        r_resp_d = merge_resp(r_resp_q, mem_oob_s);
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_first_q <= 1'b1;
            idx_q      <= {IDX_W{1'b0}};
            cnt_q      <= {LEN_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            err_q      <= 1'b0;
            b_val_q    <= 1'b0;
            b_resp_q   <= OKAY;
            r_val_q    <= 1'b0;
            r_data_q   <= {DATA_W{1'b0}};
            r_last_q   <= 1'b0;
            r_resp_q   <= OKAY;
        end else begin
            state_q    <= state_d;
            wr_first_q <= wr_first_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            b_val_q    <= b_val_d;
            b_resp_q   <= b_resp_d;
            r_val_q    <= r_val_d;
            r_data_q   <= r_data_d;
            r_last_q   <= r_last_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign aw_rdy = grant_w_s;
    assign ar_rdy = grant_r_s;
    assign w_rdy  = w_rdy_s;
    assign b_val  = b_val_q;
    assign b_resp = b_resp_q;
    assign r_val  = r_val_q;
    assign r_data = r_data_q;
    assign r_last = r_last_q;
    assign r_resp = r_resp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (honours MEM_BOUNDS_CHECK_EN).
module tb_axi_mem_slave;

    import axi_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic        aw_val, aw_rdy, ar_val, ar_rdy;
    logic [31:0] w_data, r_data;
    logic [3:0]  w_strb;
    logic        w_last, w_val, w_rdy;
    logic [1:0]  b_resp, r_resp;
    logic        b_val, b_rdy, r_last, r_val, r_rdy;

    logic [31:0] mdl [256];
    int          n_vec = 0;
    int          n_err = 0;

    axi_mem_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_val(aw_val), .aw_rdy(aw_rdy),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_val(w_val), .w_rdy(w_rdy),
        .b_resp(b_resp), .b_val(b_val), .b_rdy(b_rdy),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_val(ar_val), .ar_rdy(ar_rdy),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_val(r_val), .r_rdy(r_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aw_phase(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        aw_addr = addr; aw_len = len; aw_val = 1'b1;
        #1;
        while (!aw_rdy && n < 50) begin tick(); n++; end
        check_eq("aw_handshake", (n < 50), 1'b1);
        tick();
        aw_val = 1'b0;
    endtask

    task automatic ar_phase(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        ar_addr = addr; ar_len = len; ar_val = 1'b1;
        #1;
        while (!ar_rdy && n < 50) begin tick(); n++; end
        check_eq("ar_handshake", (n < 50), 1'b1);
        tick();
        ar_val = 1'b0;
    endtask

    // Drive len+1 W beats (w_last on beat last_beat), update model, then take B
    task automatic w_phase(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                           input logic [3:0] strb, input int last_beat, input logic [1:0] exp_resp);
        int n;
        int ui;
        for (int i = 0; i <= int'(len); i++) begin
            w_data = base + 32'(i); w_strb = strb; w_last = (i == last_beat); w_val = 1'b1;
            #1;
            n = 0;
            while (!w_rdy && n < 50) begin tick(); n++; end
            check_eq("w_beat_accept", (n < 50), 1'b1);
            ui = int'(addr >> 2) + i;
`ifdef MEM_BOUNDS_CHECK_EN
            if (ui < 256) begin
`else
            begin
`endif
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mdl[ui % 256][8*b +: 8] = w_data[8*b +: 8];
                end
            end
            tick();
        end
        w_val = 1'b0; w_last = 1'b0;
        check_eq("b_latency", b_val, 1'b1);
        check_eq("b_resp", b_resp, exp_resp);
        check_eq("w_rdy_after_last", w_rdy, 1'b0);
        b_rdy = 1'b1;
        #1;
        tick();
        b_rdy = 1'b0;
        check_eq("b_taken", b_val, 1'b0);
    endtask

    // Collect len+1 R beats; toggle=1 alternates r_rdy 1/0 to exercise stalls
    task automatic r_phase(input logic [15:0] addr, input logic [7:0] len, input bit toggle);
        int beat = 0;
        int cyc = 0;
        int ui;
        logic [31:0] exp_d;
        logic [1:0]  exp_r = 2'b00;
        check_eq("r_latency", r_val, 1'b1);
        while (beat <= int'(len) && cyc < 200) begin
            ui = int'(addr >> 2) + beat;
            exp_d = mdl[ui % 256];
`ifdef MEM_BOUNDS_CHECK_EN
            if (ui >= 256) begin exp_d = 32'h0; exp_r = 2'b10; end
`endif
            r_rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            check_eq("r_val", r_val, 1'b1);
            check_eq("r_data", r_data, exp_d);
            check_eq("r_last", r_last, (beat == int'(len)));
            check_eq("r_resp", r_resp, exp_r);
            if (r_rdy && r_val) beat++;
            tick();
            cyc++;
        end
        r_rdy = 1'b0;
        check_eq("r_done", r_val, 1'b0);
        if (!toggle) check_eq("r_no_bubbles", cyc, int'(len) + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit exp_w;
        int n;
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
        rst = 1'b1;
        aw_addr = 16'h0; aw_len = 8'h0; aw_val = 1'b0;
        w_data = 32'h0; w_strb = 4'h0; w_last = 1'b0; w_val = 1'b0; b_rdy = 1'b0;
        ar_addr = 16'h0; ar_len = 8'h0; ar_val = 1'b0; r_rdy = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_aw_rdy", aw_rdy, 1'b0);
        check_eq("rst_ar_rdy", ar_rdy, 1'b0);
        check_eq("rst_w_rdy", w_rdy, 1'b0);
        check_eq("rst_b_val", b_val, 1'b0);
        check_eq("rst_r_val", r_val, 1'b0);
        check_eq("rst_b_resp", b_resp, 2'b00);
        check_eq("rst_r_resp", r_resp, 2'b00);
        check_eq("rst_r_data", r_data, 32'h0);
        check_eq("rst_r_last", r_last, 1'b0);
        rst = 1'b0;
        tick();

        // 1: basic 4-beat write then read back
        aw_phase(16'h0010, 8'd3);
        w_phase(16'h0010, 8'd3, 32'h0000_00A0, 4'hF, 3, 2'b00);
        ar_phase(16'h0010, 8'd3);
        r_phase(16'h0010, 8'd3, 1'b0);

        // 2: byte strobes on word 5 -> 0xFF00FF00
        aw_phase(16'h0014, 8'd0);
        w_phase(16'h0014, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
        aw_phase(16'h0014, 8'd0);
        w_phase(16'h0014, 8'd0, 32'h0000_0000, 4'b0101, 0, 2'b00);
        check_eq("strb_model", mdl[5], 32'hFF00_FF00);
        ar_phase(16'h0014, 8'd0);
        r_phase(16'h0014, 8'd0, 1'b0);

        // 3: AW and AR contend; grants alternate W,R,W,R; reads stall every other cycle
        for (int k = 0; k < 4; k++) begin
            exp_w = ((k % 2) == 0);
            aw_addr = 16'h0040 + 16'(8 * (k / 2)); aw_len = 8'd1; aw_val = 1'b1;
            ar_addr = (k == 1) ? 16'h0010 : 16'h0040; ar_len = 8'd3; ar_val = 1'b1;
            #1;
            n = 0;
            while (!aw_rdy && !ar_rdy && n < 50) begin tick(); n++; end
            check_eq("arb_grant_w", aw_rdy, exp_w);
            check_eq("arb_grant_r", ar_rdy, !exp_w);
            if (aw_rdy) begin
                tick();
                aw_val = 1'b0;
                w_phase(aw_addr, 8'd1, 32'h0000_00B0 + 32'(k), 4'hF, 1, 2'b00);
            end else begin
                tick();
                ar_val = 1'b0;
                r_phase(ar_addr, 8'd3, 1'b1);
            end
        end
        aw_val = 1'b0; ar_val = 1'b0;

        // 4: early w_last on a 3-beat burst -> all 3 beats taken, SLVERR
        aw_phase(16'h0080, 8'd2);
        w_phase(16'h0080, 8'd2, 32'h0000_00D0, 4'hF, 1, 2'b10);
        ar_phase(16'h0080, 8'd2);
        r_phase(16'h0080, 8'd2, 1'b0);

        // 5: read crossing the top of the array
        aw_phase(16'h03FC, 8'd0);
        w_phase(16'h03FC, 8'd0, 32'hC0FF_EE01, 4'hF, 0, 2'b00);
        aw_phase(16'h0000, 8'd0);
        w_phase(16'h0000, 8'd0, 32'h0000_BEEF, 4'hF, 0, 2'b00);
        ar_phase(16'h03FC, 8'd1);
        r_phase(16'h03FC, 8'd1, 1'b0);

        // 6: reset in the middle of an 8-beat read
        ar_phase(16'h0010, 8'd7);
        r_rdy = 1'b1;
        check_eq("mid_beat0", r_data, mdl[4]);
        tick();
        check_eq("mid_beat1", r_data, mdl[5]);
        tick();
        r_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_r_val", r_val, 1'b0);
        check_eq("mid_rst_ar_rdy", ar_rdy, 1'b0);
        check_eq("mid_rst_r_last", r_last, 1'b0);
        check_eq("mid_rst_state", dut.state_q, IDLE);
        ar_phase(16'h0040, 8'd3);
        r_phase(16'h0040, 8'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
